// File: rtl/clfsr_gen.sv
// clfsr_gen: chaotic LFSR random-word generator.
// A Fibonacci LFSR bit is XORed with a fixed-point logistic-map bit, and the
// result is packed LSB-first into OUT_W-bit words on a valid/ready stream.
// Degenerate map states and a locked LFSR are detected and recovered.
// Optional feature macro: CLFSR_VN_WHITEN_EN adds a von Neumann corrector
// between the raw bit and the word shifter.
module clfsr_gen #(
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter int unsigned       MAP_W     = 16,
    parameter int unsigned       OUT_W     = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'h0001,
    parameter logic [MAP_W-1:0]  MAP_SEED  = 16'h2A5D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_lfsr,
    input  logic [MAP_W-1:0]  seed_map,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [7:0]        degen_cnt
);

    localparam int unsigned       CNT_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [MAP_W-1:0]  MAP_ONE   = {1'b0, {(MAP_W-1){1'b1}}};
    localparam logic [LFSR_W-1:0] LFSR_ONE  = {{(LFSR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {ST_FILL = 1'b0, ST_HOLD = 1'b1} state_t;

    // Even parity of a tap-masked LFSR vector gives the feedback bit.
    function automatic logic parity_f(input logic [LFSR_W-1:0] v);
        parity_f = ^v;
    endfunction

    state_t              state_r, state_n;
    logic [LFSR_W-1:0]   lfsr_r, lfsr_n;
    logic [MAP_W-1:0]    x_r, x_n;
    logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_n;
    logic [OUT_W-1:0]    word_r, word_n;
    logic                valid_n;
    logic [OUT_W-1:0]    data_n;
    logic [7:0]          degen_n;

    // Generator datapath for one step.
    logic                fb_s;
    logic [LFSR_W-1:0]   lfsr_shift_s, lfsr_step_s;
    logic [MAP_W-1:0]    diff_s, x_next_s, x_fallback_s, x_step_s;
    logic [2*MAP_W-1:0]  prod_s, prod_sh_s;
    logic                chaos_s, raw_s, degen_s;
    logic [LFSR_W-1:0]   seed_lfsr_s;
    logic [MAP_W-1:0]    seed_x_s;
    logic                emit_s, emit_bit_s;
    logic                unused_s;

    assign fb_s         = parity_f(lfsr_r & TAPS);
    assign lfsr_shift_s = {lfsr_r[LFSR_W-2:0], fb_s};
    assign lfsr_step_s  = (lfsr_shift_s == {LFSR_W{1'b0}}) ? LFSR_ONE : lfsr_shift_s;

    // Logistic map x*(1-x)*4 in Q1.(MAP_W-1); the <<2 supplies the factor 4.
    assign diff_s       = MAP_ONE - x_r;
    assign prod_s       = {{MAP_W{1'b0}}, x_r} * {{MAP_W{1'b0}}, diff_s};
    assign prod_sh_s    = prod_s << 2;
    assign x_next_s     = prod_sh_s[2*MAP_W-2:MAP_W-1];
    assign chaos_s      = x_next_s[MAP_W-2];
    assign raw_s        = lfsr_r[0] ^ chaos_s;

    // A zero or fixed-point map state is reseeded from the LFSR low bits.
    assign degen_s      = (x_next_s == {MAP_W{1'b0}}) || (x_next_s == x_r);
    assign x_fallback_s = (lfsr_r[MAP_W-2:0] == {(MAP_W-1){1'b0}}) ? MAP_SEED
                                                                   : {1'b0, lfsr_r[MAP_W-2:0]};
    assign x_step_s     = degen_s ? x_fallback_s : x_next_s;

    assign seed_lfsr_s  = (seed_lfsr == {LFSR_W{1'b0}}) ? LFSR_ONE : seed_lfsr;
    assign seed_x_s     = (seed_map[MAP_W-2:0] == {(MAP_W-1){1'b0}}) ? MAP_SEED
                                                                     : {1'b0, seed_map[MAP_W-2:0]};

    assign unused_s     = ^{prod_sh_s[2*MAP_W-1], prod_sh_s[MAP_W-2:0], seed_map[MAP_W-1]};

`ifdef CLFSR_VN_WHITEN_EN
    logic vn_phase_r;
    logic vn_first_r;

    // Pair tracker for the von Neumann corrector; restarts on seeding and refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vn_phase_r <= 1'b0;
            vn_first_r <= 1'b0;
        end else if (seed_load) begin
            vn_phase_r <= 1'b0;
        end else if ((state_r == ST_FILL) && en) begin
            vn_phase_r <= ~vn_phase_r;
            vn_first_r <= raw_s;
        end else if ((state_r == ST_HOLD) && out_valid && out_ready) begin
            vn_phase_r <= 1'b0;
        end else begin
            vn_phase_r <= vn_phase_r;
        end
    end

    // Pairs 01 and 10 emit their first bit; 00 and 11 are dropped.
    assign emit_s     = vn_phase_r && (vn_first_r != raw_s);
    assign emit_bit_s = vn_first_r;
`else
    assign emit_s     = 1'b1;
    assign emit_bit_s = raw_s;
`endif

    // Next-state logic: seeding first, then FILL stepping or HOLD handshake.
    always_comb begin
        state_n   = state_r;
        lfsr_n    = lfsr_r;
        x_n       = x_r;
        bit_cnt_n = bit_cnt_r;
        word_n    = word_r;
        valid_n   = out_valid;
        data_n    = out_data;
        degen_n   = degen_cnt;
        if (seed_load) begin
            lfsr_n    = seed_lfsr_s;
            x_n       = seed_x_s;
            bit_cnt_n = {CNT_W{1'b0}};
            state_n   = ST_FILL;
            valid_n   = 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (en) begin
                        lfsr_n = lfsr_step_s;
                        x_n    = x_step_s;
                        if (degen_s && (degen_cnt != 8'hFF)) begin
                            degen_n = degen_cnt + 8'd1;
                        end else begin
                            degen_n = degen_cnt;
                        end
                        if (emit_s) begin
                            word_n[bit_cnt_r] = emit_bit_s;
                            if (bit_cnt_r == LAST_CNT) begin
                                data_n    = word_n;
                                valid_n   = 1'b1;
                                state_n   = ST_HOLD;
                                bit_cnt_n = {CNT_W{1'b0}};
                            end else begin
                                bit_cnt_n = bit_cnt_r + CNT_ONE;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_r;
                        end
                    end else begin
                        state_n = ST_FILL;
                    end
                end
                ST_HOLD: begin
                    if (out_valid && out_ready) begin
                        valid_n   = 1'b0;
                        bit_cnt_n = {CNT_W{1'b0}};
                        state_n   = ST_FILL;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
                default: begin
                    state_n = ST_FILL;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_FILL;
            lfsr_r    <= LFSR_SEED;
            x_r       <= MAP_SEED;
            bit_cnt_r <= {CNT_W{1'b0}};
            word_r    <= {OUT_W{1'b0}};
            out_valid <= 1'b0;
            out_data  <= {OUT_W{1'b0}};
            degen_cnt <= 8'd0;
        end else begin
            state_r   <= state_n;
            lfsr_r    <= lfsr_n;
            x_r       <= x_n;
            bit_cnt_r <= bit_cnt_n;
            word_r    <= word_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            degen_cnt <= degen_n;
        end
    end

endmodule

// File: tb/tb_clfsr_gen.sv
// tb_clfsr_gen: directed bench for clfsr_gen with default parameters.
// A small arithmetic reference of the LFSR and logistic map supplies words.
module tb_clfsr_gen;

    localparam int TAPS_I = 'hB400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_lfsr = 16'h0000;
    logic [15:0] seed_map = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [7:0]  degen_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int m_lfsr;
    int m_x;
    int m_deg;
    logic [7:0] ref_words [2];

    clfsr_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seed_load (seed_load),
        .seed_lfsr (seed_lfsr),
        .seed_map  (seed_map),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .degen_cnt (degen_cnt)
    );

    always #5 clk = ~clk;

    // One generator step of the reference: integer arithmetic, no bit slicing.
    task automatic model_step(output int raw);
        int fb;
        longint p;
        int xn;
        fb = 0;
        for (int i = 0; i < 16; i++) begin
            if (((TAPS_I >> i) & 1) != 0) fb = fb ^ ((m_lfsr >> i) & 1);
        end
        p   = longint'(m_x) * longint'(32767 - m_x) * 4;
        xn  = int'((p >> 15) & 'hFFFF);
        raw = (m_lfsr & 1) ^ ((xn >> 14) & 1);
        if (xn == 0 || xn == m_x) begin
            m_x = m_lfsr & 'h7FFF;
            if (m_x == 0) m_x = 'h2A5D;
            if (m_deg < 255) m_deg++;
        end else begin
            m_x = xn;
        end
        m_lfsr = ((m_lfsr << 1) & 'hFFFF) | fb;
        if (m_lfsr == 0) m_lfsr = 1;
    endtask

    task automatic model_word(output logic [7:0] w);
        int r;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            model_step(r);
            w[i] = r[0];
        end
    endtask

    // Advance clock edges until out_valid is sampled high; -1 on timeout.
    task automatic wait_valid(input int limit, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid === 1'b1) done = 1'b1;
        end
        if (!done) cyc = -1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b0;
        seed_lfsr = 16'h0000;
        seed_map  = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_lfsr = 1;
        m_x    = 'h2A5D;
        m_deg  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'h00) $display("FAIL rst_data got %h want 00", out_data); else n_pass++;
        n_checks++; if (degen_cnt !== 8'h00) $display("FAIL rst_degen got %0d want 0", degen_cnt); else n_pass++;
        n_checks++; if (dut.lfsr_r !== 16'h0001) $display("FAIL rst_lfsr got %h want 0001", dut.lfsr_r); else n_pass++;
        n_checks++; if (dut.x_r !== 16'h2A5D) $display("FAIL rst_x got %h want 2a5d", dut.x_r); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dut.lfsr_r !== 16'h0001) $display("FAIL en0_lfsr got %h want 0001", dut.lfsr_r); else n_pass++;
        n_checks++; if (dut.x_r !== 16'h2A5D) $display("FAIL en0_x got %h want 2a5d", dut.x_r); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL en0_valid got %0b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_stream();
        int cyc;
        logic [7:0] exp;
        do_reset();
        en        = 1'b1;
        out_ready = 1'b1;
        for (int w = 0; w < 64; w++) begin
            wait_valid(20, cyc);
            if (w == 0) begin
                n_checks++; if (cyc != 8) $display("FAIL first_latency got %0d edges want 8", cyc); else n_pass++;
            end else begin
                n_checks++; if (cyc != 9) $display("FAIL word_interval w=%0d got %0d want 9", w, cyc); else n_pass++;
            end
            model_word(exp);
            if (w < 2) ref_words[w] = exp;
            n_checks++; if (out_data !== exp) $display("FAIL stream_word w=%0d got %h want %h", w, out_data, exp); else n_pass++;
        end
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_accept got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (degen_cnt !== m_deg[7:0]) $display("FAIL stream_degen got %0d want %0d", degen_cnt, m_deg); else n_pass++;
    endtask

    task automatic test_hold();
        int cyc;
        logic [7:0] exp;
        logic [7:0] held;
        logic [15:0] hl;
        logic [15:0] hx;
        out_ready = 1'b0;
        wait_valid(20, cyc);
        n_checks++; if (cyc != 8) $display("FAIL hold_latency got %0d want 8", cyc); else n_pass++;
        model_word(exp);
        n_checks++; if (out_data !== exp) $display("FAIL hold_word got %h want %h", out_data, exp); else n_pass++;
        held = exp;
        hl   = m_lfsr[15:0];
        hx   = m_x[15:0];
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held || dut.lfsr_r !== hl || dut.x_r !== hx)
                $display("FAIL hold_stable c=%0d got v=%0b d=%h l=%h x=%h want v=1 d=%h l=%h x=%h",
                         i, out_valid, out_data, dut.lfsr_r, dut.x_r, held, hl, hx);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL hold_release got %0b want 0", out_valid); else n_pass++;
        wait_valid(20, cyc);
        model_word(exp);
        n_checks++; if (cyc != 8) $display("FAIL hold_next_latency got %0d want 8", cyc); else n_pass++;
        n_checks++; if (out_data !== exp) $display("FAIL hold_next_word got %h want %h", out_data, exp); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_seed_zero();
        int cyc;
        logic [7:0] exp;
        en        = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        seed_load = 1'b1;
        seed_lfsr = 16'h0000;
        seed_map  = 16'h0000;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        n_checks++; if (dut.lfsr_r !== 16'h0001) $display("FAIL seed0_lfsr got %h want 0001", dut.lfsr_r); else n_pass++;
        n_checks++; if (dut.x_r !== 16'h2A5D) $display("FAIL seed0_x got %h want 2a5d", dut.x_r); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL seed0_valid got %0b want 0", out_valid); else n_pass++;
        m_lfsr = 1;
        m_x    = 'h2A5D;
        model_word(exp);
        @(posedge clk);
        #1;
        n_checks++; if (dut.x_r !== 16'h715D) $display("FAIL step1_x got %h want 715d", dut.x_r); else n_pass++;
        n_checks++; if (dut.lfsr_r !== 16'h0002) $display("FAIL step1_lfsr got %h want 0002", dut.lfsr_r); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (dut.x_r !== 16'h33D6) $display("FAIL step2_x got %h want 33d6", dut.x_r); else n_pass++;
        n_checks++; if (dut.lfsr_r !== 16'h0004) $display("FAIL step2_lfsr got %h want 0004", dut.lfsr_r); else n_pass++;
        wait_valid(20, cyc);
        n_checks++; if (cyc != 6) $display("FAIL seed0_latency got %0d want 6", cyc); else n_pass++;
        n_checks++; if (out_data !== ref_words[0]) $display("FAIL seed0_word0 got %h want %h", out_data, ref_words[0]); else n_pass++;
        n_checks++; if (out_data !== exp) $display("FAIL seed0_model0 got %h want %h", out_data, exp); else n_pass++;
        wait_valid(20, cyc);
        model_word(exp);
        n_checks++; if (out_data !== ref_words[1]) $display("FAIL seed0_word1 got %h want %h", out_data, ref_words[1]); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_degen();
        int cyc;
        logic [7:0] exp;
        do_reset();
        en        = 1'b1;
        out_ready = 1'b1;
        seed_load = 1'b1;
        seed_lfsr = 16'h1234;
        seed_map  = 16'h7FFF;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        n_checks++; if (dut.x_r !== 16'h7FFF) $display("FAIL dg_seed_x got %h want 7fff", dut.x_r); else n_pass++;
        n_checks++; if (dut.lfsr_r !== 16'h1234) $display("FAIL dg_seed_lfsr got %h want 1234", dut.lfsr_r); else n_pass++;
        m_lfsr = 'h1234;
        m_x    = 'h7FFF;
        m_deg  = 0;
        model_word(exp);
        @(posedge clk);
        #1;
        n_checks++; if (dut.x_r !== 16'h1234) $display("FAIL dg_reload_x got %h want 1234", dut.x_r); else n_pass++;
        n_checks++; if (dut.lfsr_r !== 16'h2469) $display("FAIL dg_lfsr got %h want 2469", dut.lfsr_r); else n_pass++;
        n_checks++; if (degen_cnt !== 8'd1) $display("FAIL dg_cnt got %0d want 1", degen_cnt); else n_pass++;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            n_checks++; if (dut.x_r === 16'h0000) $display("FAIL dg_x_zero got %h want nonzero", dut.x_r); else n_pass++;
        end
        n_checks++; if (cyc != 7) $display("FAIL dg_latency got %0d want 7", cyc); else n_pass++;
        n_checks++; if (out_data !== exp) $display("FAIL dg_word got %h want %h", out_data, exp); else n_pass++;
        wait_valid(20, cyc);
        model_word(exp);
        n_checks++; if (out_data !== exp) $display("FAIL dg_word2 got %h want %h", out_data, exp); else n_pass++;
        n_checks++; if (degen_cnt !== m_deg[7:0]) $display("FAIL dg_cnt_end got %0d want %0d", degen_cnt, m_deg); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_seed_in_hold();
        int cyc;
        logic [7:0] exp;
        out_ready = 1'b0;
        en        = 1'b1;
        wait_valid(20, cyc);
        model_word(exp);
        n_checks++; if (out_data !== exp) $display("FAIL sh_word got %h want %h", out_data, exp); else n_pass++;
        out_ready = 1'b1;
        seed_load = 1'b1;
        seed_lfsr = 16'h0000;
        seed_map  = 16'h0000;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL sh_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (dut.lfsr_r !== 16'h0001) $display("FAIL sh_lfsr got %h want 0001", dut.lfsr_r); else n_pass++;
        n_checks++; if (dut.x_r !== 16'h2A5D) $display("FAIL sh_x got %h want 2a5d", dut.x_r); else n_pass++;
        wait_valid(20, cyc);
        n_checks++; if (cyc != 8) $display("FAIL sh_refill got %0d want 8", cyc); else n_pass++;
        n_checks++; if (out_data !== ref_words[0]) $display("FAIL sh_word0 got %h want %h", out_data, ref_words[0]); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_en_toggle();
        int cyc;
        logic [7:0] exp;
        logic [7:0] want_words [3];
        int want_cyc [3];
        bit done;
        out_ready = 1'b1;
        seed_load = 1'b1;
        seed_lfsr = 16'h0000;
        seed_map  = 16'h0000;
        en        = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        en        = 1'b1;
        m_lfsr = 1;
        m_x    = 'h2A5D;
        for (int w = 0; w < 3; w++) begin
            model_word(exp);
            want_words[w] = exp;
        end
        want_cyc[0] = 15;
        want_cyc[1] = 16;
        want_cyc[2] = 16;
        for (int w = 0; w < 3; w++) begin
            cyc  = 0;
            done = 1'b0;
            while (!done && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
                en = ~en;
                if (out_valid === 1'b1) done = 1'b1;
            end
            n_checks++; if (cyc != want_cyc[w]) $display("FAIL tog_interval w=%0d got %0d want %0d", w, cyc, want_cyc[w]); else n_pass++;
            n_checks++; if (out_data !== want_words[w]) $display("FAIL tog_word w=%0d got %h want %h", w, out_data, want_words[w]); else n_pass++;
        end
        n_checks++; if (want_words[0] !== ref_words[0]) $display("FAIL tog_ref0 got %h want %h", want_words[0], ref_words[0]); else n_pass++;
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_seed_zero();
        test_degen();
        test_seed_in_hold();
        test_en_toggle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
